timer_req_scheduler: RTL and testbench
======================================

# timer_req_scheduler

Shares the single interval-timer peripheral between up to N_REQ watch-mode requesters (chronometer, countdown, alarm, ...). Arbitrates round-robin, programs the timer through its 16-bit register slave (period low/high, control, status), waits for the timer interrupt, clears it and returns a one-cycle tick to the owning requester. Sits between the mode logic and the timer's register port, replacing CPU-driven timer programming for hardware modes.

## Interface

Parameters:
- N_REQ, 3: number of requesters (2..8)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level; held high while the timer is wanted
- req_period  in  32*N_REQ  requester i's period in bits [32i+31:32i]; timeout interval = period+1 clk cycles
- req_cont  in  N_REQ  1 = periodic, 0 = one-shot
- grant  out  N_REQ  one-hot owner of the timer, all zero when idle
- tick  out  N_REQ  one-cycle pulse to the owner on each timeout
- busy  out  1  high in every state except IDLE
- tmr_address  out  3  timer register index (0 status, 1 control, 2 period_l, 3 period_h)
- tmr_chipselect  out  1  timer select, high only during write cycles
- tmr_write_n  out  1  active-low write strobe
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt, level, cleared by any status write

## Operation

- Timer control word: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. Start word = 0x0005 (one-shot) or 0x0007 (periodic); stop word = 0x0008; status clear word = 0x0000.
- States: IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, WR_STATUS, WR_STOP, WR_CLR.
- IDLE: if any req high, select winner round-robin starting at (last_owner+1) mod N_REQ; register grant, latch its period and cont flag; go WR_PL. last_owner resets to N_REQ-1, so req[0] wins first.
- Period of 0 is latched as 1 (guarantees a timeout edge).
- WR_PL: write period[15:0] to addr 2 -> WR_PH: write period[31:16] to addr 3 -> WR_CTRL: write start word to addr 1 -> WAIT_IRQ.
- WAIT_IRQ: owner's req low -> WR_STOP (cancel, takes priority over a same-cycle irq; no tick). Else tmr_irq high -> WR_STATUS.
- WR_STATUS: write 0x0000 to addr 0; tick[owner]=1 this cycle. Next: one-shot -> IDLE (grant cleared, timer has stopped itself); periodic with req high -> WAIT_IRQ; periodic with req low -> WR_STOP.
- WR_STOP: write stop word to addr 1 -> WR_CLR: write 0x0000 to addr 0 (discard any pending timeout) -> IDLE, grant cleared.
- Non-owner req changes, req_period/req_cont changes after latching: ignored until next arbitration.
- Bus outputs when not writing: chipselect 0, write_n 1, address 0, writedata 0.

## Timing

- Reset values: grant 0, tick 0, busy 0, tmr_chipselect 0, tmr_write_n 1, tmr_address 0, tmr_writedata 0, state IDLE, last_owner N_REQ-1.
- All outputs registered; each timer write is exactly one cycle (chipselect=1, write_n=0), no wait states, no reads.
- req high in IDLE at cycle 0 -> grant and busy high cycle 1 with period_l write; period_h cycle 2; control cycle 3; WAIT_IRQ from cycle 4.
- tmr_irq sampled high at edge k -> status write and tick in cycle k+1; irq drops in cycle k+2, so WAIT_IRQ re-entry never double-counts.
- Return to IDLE costs one cycle; a new grant cannot appear in the same cycle grant clears.
- Reset asserted mid-sequence: immediate return to reset values, any partial write aborted (timer shares reset_n).

## Test plan

- Single one-shot: req[0]=1, period 9, cont 0 -> writes (2,0x0009),(3,0x0000),(1,0x0005); irq after 10 timer cycles -> (0,0x0000) write, one tick[0], grant 0, busy 0.
- Periodic: req[1]=1, period 0x0001_0003, cont 1 -> writes (2,0x0003),(3,0x0001),(1,0x0007); three irqs -> three tick[1] pulses; drop req[1] -> (1,0x0008),(0,0x0000), IDLE.
- Round-robin: req=3'b111 all one-shot -> grant order 0,1,2,0; each owner receives exactly one tick per grant.
- Cancel with simultaneous irq: req[2] falls same cycle tmr_irq rises in WAIT_IRQ -> no tick, writes (1,0x0008) then (0,0x0000), grant cleared.
- Zero period: req[0] period 0 -> period_l write 0x0001, tick delivered.
- Reset during WR_PH: reset_n low -> next cycle all outputs at reset values, no further writes until new req after release.

Source files
------------

// File: rtl/timer_req_scheduler.sv
// timer_req_scheduler
// Round-robin owner of the shared interval timer. Programs the timer through
// its 16-bit register slave, waits for the interrupt, clears it and returns a
// one-cycle tick to the owning requester. All outputs are registered.
module timer_req_scheduler #(
  parameter int N_REQ = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [32*N_REQ-1:0]    req_period,
  input  logic [N_REQ-1:0]       req_cont,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       tick,
  output logic                   busy,
  output logic [2:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [OW-1:0] LAST_INIT = OW'(N_REQ - 1);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PL     = 3'd2;
  localparam logic [2:0] ADDR_PH     = 3'd3;

  localparam logic [15:0] CTRL_ONESHOT = 16'h0005;
  localparam logic [15:0] CTRL_PERIOD  = 16'h0007;
  localparam logic [15:0] CTRL_STOP    = 16'h0008;

  typedef enum logic [2:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, WAIT_IRQ, WR_STATUS, WR_STOP, WR_CLR
  } state_t;

  state_t         state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  last_q, last_d;
  logic [31:0]    period_q, period_d;
  logic           cont_q, cont_d;
  logic           win_found;
  logic [OW-1:0]  win_idx;
  logic [OW-1:0]  cand;
  logic           owner_req;

  logic [N_REQ-1:0] grant_d, tick_d;
  logic             busy_d, cs_d, wn_d;
  logic [2:0]       addr_d;
  logic [15:0]      data_d;

  assign owner_req = req[owner_q];

  // Round-robin search starting one past the last owner
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = OW'((32'(last_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Latch owner, period and mode at the moment of arbitration
  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    period_d = period_q;
    cont_d   = cont_q;
    if (state_q == IDLE && win_found) begin
      owner_d  = win_idx;
      last_d   = win_idx;
      period_d = req_period[32*win_idx +: 32];
      // a zero period would never produce a timeout edge
      if (period_d == '0) period_d = 32'd1;
      cont_d   = req_cont[win_idx];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; cancel wins over a same-cycle interrupt
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (win_found) state_d = WR_PL;
      WR_PL:     state_d = WR_PH;
      WR_PH:     state_d = WR_CTRL;
      WR_CTRL:   state_d = WAIT_IRQ;
      WAIT_IRQ:  if (!owner_req)   state_d = WR_STOP;
                 else if (tmr_irq) state_d = WR_STATUS;
      WR_STATUS: if (!cont_q)        state_d = IDLE;
                 else if (owner_req) state_d = WAIT_IRQ;
                 else                state_d = WR_STOP;
      WR_STOP:   state_d = WR_CLR;
      WR_CLR:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs can be registered
  always_comb begin
    grant_d = '0;
    tick_d  = '0;
    busy_d  = (state_d != IDLE);
    cs_d    = 1'b0;
    wn_d    = 1'b1;
    addr_d  = '0;
    data_d  = '0;
    if (state_d != IDLE)     grant_d[owner_d] = 1'b1;
    if (state_d == WR_STATUS) tick_d[owner_d] = 1'b1;
    case (state_d)
      WR_PL:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PL;     data_d = period_d[15:0];  end
      WR_PH:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PH;     data_d = period_d[31:16]; end
      WR_CTRL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CTRL;
                       data_d = cont_d ? CTRL_PERIOD : CTRL_ONESHOT; end
      WR_STATUS: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS; data_d = '0; end
      WR_STOP:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CTRL;   data_d = CTRL_STOP; end
      WR_CLR:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS; data_d = '0; end
      default:   ;
    endcase
  end

  // Arbitration and latched-request registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= '0;
      last_q   <= LAST_INIT;
      period_q <= '0;
      cont_q   <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      last_q   <= last_d;
      period_q <= period_d;
      cont_q   <= cont_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant          <= '0;
      tick           <= '0;
      busy           <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      grant          <= grant_d;
      tick           <= tick_d;
      busy           <= busy_d;
      tmr_chipselect <= cs_d;
      tmr_write_n    <= wn_d;
      tmr_address    <= addr_d;
      tmr_writedata  <= data_d;
    end
  end

endmodule

// File: tb/tb_timer_req_scheduler.sv
// Testbench for timer_req_scheduler: a behavioural interval-timer peripheral,
// a bus/tick monitor and a transaction-level model of arbitration order.
module tb_timer_req_scheduler;

  localparam int N = 3;
  typedef logic [18:0] wr_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     req;
  logic [32*N-1:0]  req_period;
  logic [N-1:0]     req_cont;
  logic [N-1:0]     grant, tick;
  logic             busy;
  logic [2:0]       tmr_address;
  logic             tmr_chipselect, tmr_write_n;
  logic [15:0]      tmr_writedata;
  logic             tmr_irq;

  logic             model_en, man_irq;
  logic [31:0]      m_per, m_cnt;
  logic             m_run, m_cont, m_irq;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t          wq[$];
  int           tq[$];
  logic [N-1:0] gq[$];
  logic [N-1:0] gprev;
  int viol_grant = 0, viol_tick = 0, viol_bus = 0;

  wr_t          exp_w[$];
  int           exp_t[$];
  logic [N-1:0] exp_g[$];
  int           model_last;
  int           cfg_rem[N];
  logic [31:0]  cfg_per[N];
  logic         cfg_cont[N];
  int           run_rem[N];

  always #5 clk = ~clk;

  assign tmr_irq = (model_en & m_irq) | man_irq;

  timer_req_scheduler #(.N_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_period(req_period),
    .req_cont(req_cont), .grant(grant), .tick(tick), .busy(busy),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq)
  );

  // Interval timer: timeout every period+1 cycles, irq cleared by status write
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_per <= '0; m_cnt <= '0; m_run <= 1'b0; m_cont <= 1'b0; m_irq <= 1'b0;
    end else if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: m_irq <= 1'b0;
        3'd1: if (tmr_writedata[3]) m_run <= 1'b0;
              else if (tmr_writedata[2]) begin
                m_run <= 1'b1; m_cnt <= m_per; m_cont <= tmr_writedata[1];
              end
        3'd2: m_per[15:0]  <= tmr_writedata;
        3'd3: m_per[31:16] <= tmr_writedata;
        default: ;
      endcase
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_irq <= 1'b1;
        if (m_cont) m_cnt <= m_per;
        else        m_run <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end
  end

  // Monitor: record writes, ticks and new grants; flag protocol breaches
  always @(negedge clk) begin
    if (tmr_chipselect && !tmr_write_n) wq.push_back({tmr_address, tmr_writedata});
    if ((tmr_chipselect != !tmr_write_n) ||
        (!tmr_chipselect && (tmr_address != 0 || tmr_writedata != 0)))
      viol_bus <= viol_bus + 1;
    for (int i = 0; i < N; i++) if (tick[i]) tq.push_back(i);
    if (tick != 0 && tick != grant) viol_tick <= viol_tick + 1;
    if (grant != 0 && grant != gprev) begin
      gq.push_back(grant);
      if (gprev != 0) viol_grant <= viol_grant + 1;
    end
    if ($countones(grant) > 1) viol_grant <= viol_grant + 1;
    gprev <= grant;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    wq.delete(); tq.delete(); gq.delete();
  endtask

  // Transaction model: who wins next, which writes and ticks each grant yields
  task automatic model_build();
    int rem[N];
    int c;
    bit found;
    logic [31:0] p;
    exp_w.delete(); exp_t.delete(); exp_g.delete();
    for (int i = 0; i < N; i++) rem[i] = cfg_rem[i];
    c = 0;
    forever begin
      found = 1'b0;
      for (int k = 1; k <= N; k++)
        if (!found && rem[(model_last + k) % N] > 0) begin
          found = 1'b1; c = (model_last + k) % N;
        end
      if (!found) break;
      model_last = c;
      p = (cfg_per[c] == 0) ? 32'd1 : cfg_per[c];
      exp_g.push_back(N'(1) << c);
      exp_w.push_back({3'd2, p[15:0]});
      exp_w.push_back({3'd3, p[31:16]});
      exp_w.push_back({3'd1, cfg_cont[c] ? 16'h0007 : 16'h0005});
      if (cfg_cont[c]) begin
        repeat (rem[c]) begin exp_w.push_back({3'd0, 16'h0000}); exp_t.push_back(c); end
        exp_w.push_back({3'd1, 16'h0008});
        exp_w.push_back({3'd0, 16'h0000});
        rem[c] = 0;
      end else begin
        exp_w.push_back({3'd0, 16'h0000}); exp_t.push_back(c);
        rem[c]--;
      end
    end
  endtask

  function automatic int wr_diff();
    int n = (wq.size() > exp_w.size()) ? wq.size() : exp_w.size();
    for (int i = 0; i < n; i++)
      if (i >= wq.size() || i >= exp_w.size() || wq[i] !== exp_w[i]) return i;
    return -1;
  endfunction

  function automatic int tk_diff();
    int n = (tq.size() > exp_t.size()) ? tq.size() : exp_t.size();
    for (int i = 0; i < n; i++)
      if (i >= tq.size() || i >= exp_t.size() || tq[i] != exp_t[i]) return i;
    return -1;
  endfunction

  function automatic int gr_diff();
    int n = (gq.size() > exp_g.size()) ? gq.size() : exp_g.size();
    for (int i = 0; i < n; i++)
      if (i >= gq.size() || i >= exp_g.size() || gq[i] !== exp_g[i]) return i;
    return -1;
  endfunction

  function automatic string wstr(int i, bit act);
    wr_t w;
    if (act) begin if (i < 0 || i >= wq.size()) return "none"; w = wq[i]; end
    else     begin if (i < 0 || i >= exp_w.size()) return "none"; w = exp_w[i]; end
    return $sformatf("(%0d,0x%04h)", w[18:16], w[15:0]);
  endfunction

  task automatic setup_reqs();
    for (int i = 0; i < N; i++) begin
      run_rem[i] = cfg_rem[i];
      req[i] = (cfg_rem[i] > 0);
      req_period[32*i +: 32] = cfg_per[i];
      req_cont[i] = cfg_cont[i];
    end
  endtask

  // Requesters hold req until they have collected their wanted ticks
  task automatic run_loop(input int budget, output bit timed_out);
    int n = 0;
    timed_out = 1'b0;
    while (1) begin
      if (req == 0 && !busy) break;
      if (n >= budget) begin timed_out = 1'b1; break; end
      cycle(); n++;
      for (int i = 0; i < N; i++)
        if (tick[i]) begin
          run_rem[i]--;
          if (run_rem[i] <= 0) req[i] = 1'b0;
        end
    end
  endtask

  task automatic test_reset();
    model_en = 1'b1; man_irq = 1'b0;
    req = '0; req_period = '0; req_cont = '0;
    reset_n = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;
    model_last = N - 1;
    cycle();
    n_checks++; if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b required 000", grant); end
    n_checks++; if (tick !== '0) begin n_fail++; $display("FAIL reset_tick: got %b required 000", tick); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (tmr_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b required 0", tmr_chipselect); end
    n_checks++; if (tmr_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_write_n: got %b required 1", tmr_write_n); end
    n_checks++; if (tmr_address !== 3'd0) begin n_fail++; $display("FAIL reset_addr: got %0d required 0", tmr_address); end
    n_checks++; if (tmr_writedata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got 0x%04h required 0x0000", tmr_writedata); end
  endtask

  task automatic test_round_robin();
    bit to; int d;
    cfg_rem = '{2, 1, 1}; cfg_per = '{32'd3, 32'd5, 32'd2}; cfg_cont = '{1'b0, 1'b0, 1'b0};
    clear_obs(); model_build(); setup_reqs();
    run_loop(2000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rr_timeout: got busy, required idle within budget"); end
    d = gr_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL rr_grants: at #%0d got %b required %b", d, (d < gq.size()) ? gq[d] : 3'b0, (d < exp_g.size()) ? exp_g[d] : 3'b0); end
    d = tk_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL rr_ticks: got %0d ticks required %0d (first diff #%0d)", tq.size(), exp_t.size(), d); end
    d = wr_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL rr_writes: at #%0d got %s required %s", d, wstr(d, 1), wstr(d, 0)); end
  endtask

  task automatic test_oneshot();
    bit to; int d;
    cfg_rem = '{1, 0, 0}; cfg_per = '{32'd9, 32'd0, 32'd0}; cfg_cont = '{1'b0, 1'b0, 1'b0};
    clear_obs(); model_build(); setup_reqs();
    cycle();
    n_checks++;
    if ({grant, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {3'b001, 1'b1, 1'b1, 1'b0, 3'd2, 16'h0009}) begin
      n_fail++; $display("FAIL oneshot_cycle1: got grant=%b busy=%b cs=%b wn=%b (%0d,0x%04h) required 001 1 1 0 (2,0x0009)",
                         grant, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata); end
    cycle();
    n_checks++; if ({tmr_chipselect, tmr_address, tmr_writedata} !== {1'b1, 3'd3, 16'h0000}) begin
      n_fail++; $display("FAIL oneshot_cycle2: got cs=%b (%0d,0x%04h) required 1 (3,0x0000)", tmr_chipselect, tmr_address, tmr_writedata); end
    cycle();
    n_checks++; if ({tmr_chipselect, tmr_address, tmr_writedata} !== {1'b1, 3'd1, 16'h0005}) begin
      n_fail++; $display("FAIL oneshot_cycle3: got cs=%b (%0d,0x%04h) required 1 (1,0x0005)", tmr_chipselect, tmr_address, tmr_writedata); end
    run_loop(500, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL oneshot_timeout: got busy, required idle within budget"); end
    d = wr_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL oneshot_writes: at #%0d got %s required %s", d, wstr(d, 1), wstr(d, 0)); end
    d = tk_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL oneshot_ticks: got %0d ticks required %0d", tq.size(), exp_t.size()); end
    n_checks++; if ({grant, busy} !== 4'b0000) begin n_fail++;
      $display("FAIL oneshot_idle: got grant=%b busy=%b required 000 0", grant, busy); end
  endtask

  task automatic test_periodic();
    int d, t;
    cfg_rem = '{0, 3, 0}; cfg_per = '{32'd0, 32'h0001_0003, 32'd0}; cfg_cont = '{1'b0, 1'b1, 1'b0};
    clear_obs(); model_build(); setup_reqs();
    model_en = 1'b0;
    repeat (4) cycle();
    for (int n = 0; n < 3; n++) begin
      man_irq = 1'b1;
      t = 0;
      do begin cycle(); t++; end while (!tick[1] && t < 10);
      n_checks++; if (!tick[1]) begin n_fail++; $display("FAIL periodic_tick%0d: got no tick[1], required tick", n); end
      man_irq = 1'b0;
      if (n == 2) req[1] = 1'b0;
      cycle();
    end
    t = 0;
    while (busy && t < 10) begin cycle(); t++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL periodic_idle: got busy=%b required 0", busy); end
    d = wr_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL periodic_writes: at #%0d got %s required %s", d, wstr(d, 1), wstr(d, 0)); end
    d = tk_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL periodic_ticks: got %0d ticks required %0d", tq.size(), exp_t.size()); end
    model_en = 1'b1;
  endtask

  task automatic test_cancel();
    int d;
    clear_obs();
    exp_w.delete(); exp_t.delete(); exp_g.delete();
    exp_w.push_back({3'd2, 16'h0005}); exp_w.push_back({3'd3, 16'h0000});
    exp_w.push_back({3'd1, 16'h0005}); exp_w.push_back({3'd1, 16'h0008});
    exp_w.push_back({3'd0, 16'h0000});
    model_last = 2;
    model_en = 1'b0;
    req = 3'b100; req_cont = '0; req_period = '0; req_period[64 +: 32] = 32'd5;
    repeat (4) cycle();
    req[2] = 1'b0; man_irq = 1'b1;
    cycle();
    n_checks++; if ({tick, tmr_chipselect, tmr_address, tmr_writedata} !== {3'b000, 1'b1, 3'd1, 16'h0008}) begin n_fail++;
      $display("FAIL cancel_stop: got tick=%b cs=%b (%0d,0x%04h) required 000 1 (1,0x0008)", tick, tmr_chipselect, tmr_address, tmr_writedata); end
    cycle();
    n_checks++; if ({tick, tmr_chipselect, tmr_address, tmr_writedata} !== {3'b000, 1'b1, 3'd0, 16'h0000}) begin n_fail++;
      $display("FAIL cancel_clr: got tick=%b cs=%b (%0d,0x%04h) required 000 1 (0,0x0000)", tick, tmr_chipselect, tmr_address, tmr_writedata); end
    man_irq = 1'b0;
    cycle();
    n_checks++; if ({grant, busy} !== 4'b0000) begin n_fail++;
      $display("FAIL cancel_idle: got grant=%b busy=%b required 000 0", grant, busy); end
    n_checks++; if (tq.size() != 0) begin n_fail++; $display("FAIL cancel_noticks: got %0d ticks required 0", tq.size()); end
    d = wr_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL cancel_writes: at #%0d got %s required %s", d, wstr(d, 1), wstr(d, 0)); end
    model_en = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_zero_period();
    bit to; int d;
    cfg_rem = '{1, 0, 0}; cfg_per = '{32'd0, 32'd0, 32'd0}; cfg_cont = '{1'b0, 1'b0, 1'b0};
    clear_obs(); model_build(); setup_reqs();
    run_loop(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL zero_timeout: got busy, required idle within budget"); end
    n_checks++; if (wq.size() == 0 || wq[0] !== {3'd2, 16'h0001}) begin n_fail++;
      $display("FAIL zero_pl: got %s required (2,0x0001)", wstr(0, 1)); end
    d = tk_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL zero_ticks: got %0d ticks required %0d", tq.size(), exp_t.size()); end
  endtask

  task automatic test_random();
    bit to; int d;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        cfg_rem[i]  = $urandom_range(0, 3);
        cfg_per[i]  = $urandom_range(0, 20);
        cfg_cont[i] = 1'($urandom_range(0, 1));
      end
      if (cfg_rem[0] + cfg_rem[1] + cfg_rem[2] == 0) cfg_rem[r % N] = 1;
      clear_obs(); model_build(); setup_reqs();
      run_loop(3000, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: got busy, required idle within budget", r); end
      d = gr_diff();
      n_checks++; if (d != -1) begin n_fail++;
        $display("FAIL rand%0d_grants: at #%0d got %b required %b", r, d, (d < gq.size()) ? gq[d] : 3'b0, (d < exp_g.size()) ? exp_g[d] : 3'b0); end
      d = tk_diff();
      n_checks++; if (d != -1) begin n_fail++;
        $display("FAIL rand%0d_ticks: got %0d ticks required %0d (first diff #%0d)", r, tq.size(), exp_t.size(), d); end
      d = wr_diff();
      n_checks++; if (d != -1) begin n_fail++;
        $display("FAIL rand%0d_writes: at #%0d got %s required %s", r, d, wstr(d, 1), wstr(d, 0)); end
    end
  endtask

  task automatic test_reset_mid();
    bit to; int d; int n0;
    cfg_rem = '{1, 0, 0}; cfg_per = '{32'd50, 32'd0, 32'd0}; cfg_cont = '{1'b0, 1'b0, 1'b0};
    clear_obs(); setup_reqs();
    cycle(); cycle();
    n_checks++; if ({tmr_chipselect, tmr_address} !== {1'b1, 3'd3}) begin n_fail++;
      $display("FAIL rstmid_inph: got cs=%b addr=%0d required 1 3", tmr_chipselect, tmr_address); end
    reset_n = 1'b0; req = '0;
    #1;
    n_checks++;
    if ({grant, tick, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !== {3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0}) begin
      n_fail++; $display("FAIL rstmid_outputs: got grant=%b tick=%b busy=%b cs=%b wn=%b (%0d,0x%04h) required 000 000 0 0 1 (0,0x0000)",
                         grant, tick, busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata); end
    cycle(); cycle();
    reset_n = 1'b1;
    model_last = N - 1;
    n0 = wq.size();
    repeat (5) cycle();
    n_checks++; if (wq.size() != n0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_quiet: got %0d new writes busy=%b required 0 writes busy=0", wq.size() - n0, busy); end
    cfg_rem = '{1, 1, 0}; cfg_per = '{32'd4, 32'd7, 32'd0};
    clear_obs(); model_build(); setup_reqs();
    run_loop(500, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rstmid_timeout: got busy, required idle within budget"); end
    d = gr_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL rstmid_grants: at #%0d got %b required %b", d, (d < gq.size()) ? gq[d] : 3'b0, (d < exp_g.size()) ? exp_g[d] : 3'b0); end
    d = wr_diff();
    n_checks++; if (d != -1) begin n_fail++;
      $display("FAIL rstmid_writes: at #%0d got %s required %s", d, wstr(d, 1), wstr(d, 0)); end
  endtask

  task automatic test_protocol();
    n_checks++; if (viol_grant != 0) begin n_fail++; $display("FAIL proto_grant: got %0d grant violations required 0", viol_grant); end
    n_checks++; if (viol_tick != 0) begin n_fail++; $display("FAIL proto_tick: got %0d tick violations required 0", viol_tick); end
    n_checks++; if (viol_bus != 0) begin n_fail++; $display("FAIL proto_bus: got %0d idle-bus violations required 0", viol_bus); end
  endtask

  initial begin
    gprev = '0;
    test_reset();
    test_round_robin();
    test_oneshot();
    test_periodic();
    test_cancel();
    test_zero_period();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
